// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART receive definitions: the receiver FSM state encoding, the
// oversampling ratios (13X / 16X), the mid-bit oversample counts and the
// widths of the tick divider and oversample counters.
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int unsigned OSM_13 = 13;
  localparam int unsigned OSM_16 = 16;
  localparam int unsigned MID_13 = 6;
  localparam int unsigned MID_16 = 8;

  // Width of the m_clk-per-tick divider value and of the oversample counter
  localparam int unsigned DIV_W = 16;
  localparam int unsigned OSC_W = 4;

  // Last oversample count before the counter wraps (OSM-1)
  function automatic logic [OSC_W-1:0] osm_last(input logic osm16);
    return osm16 ? OSC_W'(OSM_16 - 1) : OSC_W'(OSM_13 - 1);
  endfunction

  // Oversample count that marks the middle of the start bit
  function automatic logic [OSC_W-1:0] mid_point(input logic osm16);
    return osm16 ? OSC_W'(MID_16) : OSC_W'(MID_13);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// ---------------------------------------------------------------------------
// baud_tick_gen
// Free-running oversample tick divider. Counts 0..i_div-1 on every m_clk
// rising edge and strobes o_os_tick while the count equals i_div-1.
//
// Ports
//   m_clk      in   clock
//   reset_n    in   asynchronous active-low reset
//   i_div      in   m_clk cycles per oversample tick
//   i_restart  in   synchronous restart of the count from 0
//   o_os_tick  out  one-cycle oversample strobe
// ---------------------------------------------------------------------------
module baud_tick_gen
  import uart_pkg::*;
(
  input  logic             m_clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_restart,
  output logic             o_os_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_last;

  assign w_last    = (r_cnt == (i_div - 1'b1));
  assign o_os_tick = w_last;

  // Divider count; a restart realigns it to the newly latched rate
  always_ff @(posedge m_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_restart || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rx_sample_ctrl.sv
// ---------------------------------------------------------------------------
// rx_sample_ctrl
// UART receive sampling controller. Synchronizes rx, generates the
// oversample tick for the selected mode, finds the start bit, and strobes
// one sample per data bit (LSB first) followed by a stop-bit check.
//
// Ports
//   m_clk       in   clock, all logic on the rising edge
//   reset_n     in   asynchronous active-low reset
//   osm_sel     in   0 = 13X, 1 = 16X oversampling
//   br          in   0 = 9600, 1 = 19200 baud
//   rx          in   asynchronous serial line, idles high
//   os_tick     out  one-cycle oversample strobe
//   sample_en   out  one-cycle strobe: sample data bit now
//   rx_bit      out  synchronized rx value, valid with sample_en
//   bit_idx     out  data bit index 0..7, valid with sample_en
//   frame_done  out  one-cycle pulse at the stop-bit sample
//   frame_err   out  valid with frame_done: stop bit sampled low
//   busy        out  high whenever a frame is in progress
// ---------------------------------------------------------------------------
module rx_sample_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DIV_13_9600  = 128,
  parameter int unsigned DIV_13_19200 = 64,
  parameter int unsigned DIV_16_9600  = 104,
  parameter int unsigned DIV_16_19200 = 52
) (
  input  logic       m_clk,
  input  logic       reset_n,
  input  logic       osm_sel,
  input  logic       br,
  input  logic       rx,
  output logic       os_tick,
  output logic       sample_en,
  output logic       rx_bit,
  output logic [2:0] bit_idx,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);

  logic             r_sync1;
  logic             r_sync2;
  logic             w_rx_s;

  logic [1:0]       r_cfg;
  logic [1:0]       w_cfg_in;
  logic             w_cfg_load;
  logic [DIV_W-1:0] w_div;
  logic [OSC_W-1:0] w_osm_last;
  logic [OSC_W-1:0] w_mid;

  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic [OSC_W-1:0] r_os_cnt;
  logic [OSC_W-1:0] w_os_cnt_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_nxt;
  logic             r_prev_hi;
  logic             w_os_tick;

  assign w_rx_s     = r_sync2;
  assign rx_bit     = r_sync2;
  assign bit_idx    = r_bit_idx;
  assign busy       = (r_state != IDLE);
  assign os_tick    = w_os_tick;

  assign w_cfg_in   = {osm_sel, br};
  assign w_cfg_load = (r_state == IDLE) && (w_cfg_in != r_cfg);
  assign w_osm_last = osm_last(r_cfg[1]);
  assign w_mid      = mid_point(r_cfg[1]);

  // Two-flop synchronizer; preset high so a reset never looks like a start
  always_ff @(posedge m_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Mode is only picked up between frames so a frame keeps its bit timing
  always_ff @(posedge m_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cfg <= 2'b00;
    end else if (w_cfg_load) begin
      r_cfg <= w_cfg_in;
    end
  end

  always_comb begin
    case (r_cfg)
      2'b00:   w_div = DIV_W'(DIV_13_9600);
      2'b01:   w_div = DIV_W'(DIV_13_19200);
      2'b10:   w_div = DIV_W'(DIV_16_9600);
      default: w_div = DIV_W'(DIV_16_19200);
    endcase
  end

  baud_tick_gen u_tick (
    .m_clk     (m_clk),
    .reset_n   (reset_n),
    .i_div     (w_div),
    .i_restart (w_cfg_load),
    .o_os_tick (w_os_tick)
  );

  // Remembers that the line was high during the previous IDLE cycle, so a
  // start needs a real 1->0 edge seen from IDLE, never one left over from
  // the stop bit of the previous frame
  always_ff @(posedge m_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_hi <= 1'b0;
    end else begin
      r_prev_hi <= (r_state == IDLE) && w_rx_s;
    end
  end

  // State, oversample counter and bit index registers
  always_ff @(posedge m_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_os_cnt  <= '0;
      r_bit_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_os_cnt  <= w_os_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
    end
  end

  // Next-state and strobe logic. The counter is zeroed at the middle of the
  // start bit, so from then on each wrap (count == OSM-1) lands on the
  // middle of the next bit, exactly OSM ticks later.
  always_comb begin
    w_state_nxt   = r_state;
    w_os_cnt_nxt  = r_os_cnt;
    w_bit_idx_nxt = r_bit_idx;
    sample_en     = 1'b0;
    frame_done    = 1'b0;
    frame_err     = 1'b0;

    case (r_state)
      IDLE: begin
        if (r_prev_hi && !w_rx_s) begin
          w_state_nxt  = START;
          w_os_cnt_nxt = '0;
        end
      end

      START: begin
        if (w_os_tick) begin
          if (r_os_cnt == w_mid) begin
            w_os_cnt_nxt = '0;
            if (!w_rx_s) begin
              w_state_nxt   = DATA;
              w_bit_idx_nxt = 3'd0;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_os_cnt_nxt = r_os_cnt + 1'b1;
          end
        end
      end

      DATA: begin
        if (w_os_tick) begin
          if (r_os_cnt == w_osm_last) begin
            sample_en    = 1'b1;
            w_os_cnt_nxt = '0;
            if (r_bit_idx == 3'd7) begin
              w_state_nxt = STOP;
            end else begin
              w_bit_idx_nxt = r_bit_idx + 1'b1;
            end
          end else begin
            w_os_cnt_nxt = r_os_cnt + 1'b1;
          end
        end
      end

      STOP: begin
        if (w_os_tick) begin
          if (r_os_cnt == w_osm_last) begin
            frame_done    = 1'b1;
            frame_err     = ~w_rx_s;
            w_state_nxt   = IDLE;
            w_os_cnt_nxt  = '0;
            w_bit_idx_nxt = 3'd0;
          end else begin
            w_os_cnt_nxt = r_os_cnt + 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt   = IDLE;
        w_os_cnt_nxt  = '0;
        w_bit_idx_nxt = 3'd0;
      end
    endcase
  end

endmodule

// File: doc/rx_sample_ctrl.md
RX_SAMPLE_CTRL -- requirements
Module: rx_sample_ctrl

Interface
REQ-001 Parameter DIV_13_9600, default 128: m_clk cycles per oversample tick, 13X, 9600 baud.
REQ-002 Parameter DIV_13_19200, default 64: m_clk cycles per oversample tick, 13X, 19200 baud.
REQ-003 Parameter DIV_16_9600, default 104: m_clk cycles per oversample tick, 16X, 9600 baud.
REQ-004 Parameter DIV_16_19200, default 52: m_clk cycles per oversample tick, 16X, 19200 baud.
REQ-005 m_clk  in  1  single clock; all logic on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 osm_sel  in  1  0 = 13X oversampling, 1 = 16X oversampling (from mode register).
REQ-008 br  in  1  0 = 9600 baud, 1 = 19200 baud (from mode register).
REQ-009 rx  in  1  asynchronous serial line; idles high.
REQ-010 os_tick  out  1  one-cycle oversample strobe.
REQ-011 sample_en  out  1  one-cycle strobe: sample data bit now.
REQ-012 rx_bit  out  1  synchronized rx value, valid with sample_en.
REQ-013 bit_idx  out  3  data bit index 0..7 (LSB first), valid with sample_en.
REQ-014 frame_done  out  1  one-cycle pulse at stop-bit sample.
REQ-015 frame_err  out  1  valid with frame_done: 1 = stop bit sampled low.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 rx passes through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle latency).
REQ-018 Tick divider counts 0..DIV-1 and asserts os_tick when the count equals DIV-1; it runs continuously, also in IDLE.
REQ-019 DIV and OSM (13 or 16) are selected by {osm_sel,br}; both are latched into a config register only in IDLE, so mode changes mid-frame take effect at the next frame.
REQ-020 When a config change is latched, the divider restarts from 0.
REQ-021 FSM states: IDLE, START, DATA, STOP.
REQ-022 IDLE -> START on a synchronized 1->0 transition of rx; oversample counter cleared to 0 on entry.
REQ-023 Oversample counter increments on os_tick and wraps at OSM-1; the mid-bit point is count == 6 (13X) or count == 8 (16X).
REQ-024 START: at the mid-bit point, rx==0 -> DATA with bit_idx=0 and oversample counter cleared; rx==1 -> false start, back to IDLE with no output pulses.
REQ-025 DATA: every OSM ticks, at the mid-bit point, assert sample_en for one cycle with the current rx_bit and bit_idx; after bit_idx 7 is sampled -> STOP, otherwise increment bit_idx.
REQ-026 STOP: at the mid-bit point, pulse frame_done with frame_err = ~rx_bit, then -> IDLE in the same cycle.
REQ-027 A falling edge seen in the same cycle as the IDLE return is ignored; detection needs rx==1 for at least one cycle while in IDLE.
REQ-028 sample_en and frame_done are never asserted together; exactly 8 sample_en pulses precede each frame_done.
REQ-029 rx glitches between sample points have no effect (single sample per bit).

Reset
REQ-030 While reset_n is low: state=IDLE; counters, bit_idx and synchronizer flops set to 1 (synchronizer) or 0 (all others); all outputs 0 except rx_bit=1; config = 13X, 9600.
REQ-031 Reset asserted mid-frame aborts the frame immediately, with no frame_done.

Structure
REQ-032 State encoding, OSM constants (13, 16) and mid-bit constants (6, 8) live in the shared uart_pkg package.
REQ-033 The tick divider is a separate sub-module, baud_tick_gen (inputs DIV and restart, output os_tick).

Verification
REQ-034 Default config, rx sends 0xA5 with a good stop bit -> sample_en bits 1,0,1,0,0,1,0,1 at idx 0..7, then frame_done=1 with frame_err=0; 128*13 cycles between samples.
REQ-035 osm_sel=1, br=1, frame 0x3C -> samples 52*16=832 cycles apart, data correct, frame_err=0.
REQ-036 rx low for 3 ticks then high -> START aborts to IDLE; no sample_en, no frame_done, busy falls.
REQ-037 Stop bit held low -> frame_done=1 with frame_err=1.
REQ-038 Toggle osm_sel during DATA -> spacing stays at OSM*DIV of the original mode for the rest of the frame; the next frame uses the new mode.
REQ-039 reset_n pulsed low during bit 4 -> all outputs 0, state IDLE, no frame_done; next frame is received correctly.
